// File: rtl/ps2_letter_input_pkg.sv
// Shared definitions for the PS/2 letter front-end of the Enigma core.
//   rx_state_t    : frame receiver FSM states
//   SC_BREAK/SC_EXT : Set-2 prefix bytes
//   ASCII_A       : reset value of the letter output
//   sc_to_letter  : Set-2 make code -> {valid, uppercase ASCII}
package ps2_letter_input_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef struct packed {
    logic       valid;
    logic [7:0] ascii;
  } letter_t;

  function automatic letter_t sc_to_letter(input logic [7:0] code);
    letter_t r;
    r.valid = 1'b1;
    r.ascii = ASCII_A;
    case (code)
      8'h1C: r.ascii = ASCII_A + 8'd0;   // A
      8'h32: r.ascii = ASCII_A + 8'd1;   // B
      8'h21: r.ascii = ASCII_A + 8'd2;   // C
      8'h23: r.ascii = ASCII_A + 8'd3;   // D
      8'h24: r.ascii = ASCII_A + 8'd4;   // E
      8'h2B: r.ascii = ASCII_A + 8'd5;   // F
      8'h34: r.ascii = ASCII_A + 8'd6;   // G
      8'h33: r.ascii = ASCII_A + 8'd7;   // H
      8'h43: r.ascii = ASCII_A + 8'd8;   // I
      8'h3B: r.ascii = ASCII_A + 8'd9;   // J
      8'h42: r.ascii = ASCII_A + 8'd10;  // K
      8'h4B: r.ascii = ASCII_A + 8'd11;  // L
      8'h3A: r.ascii = ASCII_A + 8'd12;  // M
      8'h31: r.ascii = ASCII_A + 8'd13;  // N
      8'h44: r.ascii = ASCII_A + 8'd14;  // O
      8'h4D: r.ascii = ASCII_A + 8'd15;  // P
      8'h15: r.ascii = ASCII_A + 8'd16;  // Q
      8'h2D: r.ascii = ASCII_A + 8'd17;  // R
      8'h1B: r.ascii = ASCII_A + 8'd18;  // S
      8'h2C: r.ascii = ASCII_A + 8'd19;  // T
      8'h3C: r.ascii = ASCII_A + 8'd20;  // U
      8'h2A: r.ascii = ASCII_A + 8'd21;  // V
      8'h1D: r.ascii = ASCII_A + 8'd22;  // W
      8'h22: r.ascii = ASCII_A + 8'd23;  // X
      8'h35: r.ascii = ASCII_A + 8'd24;  // Y
      8'h1A: r.ascii = ASCII_A + 8'd25;  // Z
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_letter_input_if.sv
// Letter bus from the keyboard front-end to the Enigma core.
//   char_ascii   : last accepted uppercase letter, held between strobes
//   char_pressed : one-cycle strobe per accepted key press (rotor-step)
//   frame_error  : one-cycle pulse per rejected PS/2 frame
//   master = keyboard front-end, slave = Enigma core
interface ps2_letter_input_if;
  logic [7:0] char_ascii;
  logic       char_pressed;
  logic       frame_error;

  modport master (output char_ascii, output char_pressed, output frame_error);
  modport slave  (input  char_ascii, input  char_pressed, input  frame_error);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: line synchronisers, frame FSM and
// inactivity timeout. Emits one registered byte_valid pulse per good frame
// and a registered frame_error pulse on bad start/stop, timeout, or (with
// PS2_PARITY_CHECK_EN defined) an odd-parity failure.
//   clk, resetn        : system clock, async active-low reset
//   ps2_clk, ps2_data  : raw asynchronous keyboard lines
//   byte_valid         : one-cycle pulse, byte_data is valid
//   byte_data          : last received byte
//   frame_error        : one-cycle error pulse
module ps2_frame_rx
  import ps2_letter_input_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Lines idle high, so synchronisers reset to 1 to avoid a fake edge.
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   fall, dat;

  rx_state_t state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          bv_n, fe_n, par_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign dat  = dat_sync[SYNC_STAGES-1];

`ifdef PS2_PARITY_CHECK_EN
  logic par, par_n;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) par <= 1'b0;
    else         par <= par_n;
  end
  always_comb begin
    par_n = par;
    if (fall && state == RX_PARITY) par_n = dat;
  end
  assign par_ok = ^{shreg, par};     // odd parity over data + parity
`else
  assign par_ok = 1'b1;              // parity bit sampled and discarded
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= RX_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      tcnt        <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      tcnt        <= tcnt_n;
      byte_valid  <= bv_n;
      frame_error <= fe_n;
    end
  end

  assign byte_data = shreg;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tcnt_n    = tcnt;
    bv_n      = 1'b0;
    fe_n      = 1'b0;
    // A sample event always reloads; timeout only fires between edges.
    if (state == RX_IDLE || fall)             tcnt_n = '0;
    else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      tcnt_n  = '0;
      state_n = RX_IDLE;
      fe_n    = 1'b1;
    end else                                  tcnt_n = tcnt + 1'b1;
    if (fall) begin
      case (state)
        RX_IDLE:   if (!dat) begin
                     state_n   = RX_DATA;
                     bit_cnt_n = '0;
                   end
        RX_DATA:   begin
                     shreg_n   = {dat, shreg[7:1]};
                     bit_cnt_n = bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) state_n = RX_PARITY;
                   end
        RX_PARITY: state_n = RX_STOP;
        RX_STOP:   begin
                     state_n = RX_IDLE;
                     if (dat && par_ok) bv_n = 1'b1;
                     else               fe_n = 1'b1;
                   end
        default:   state_n = RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_letter_input.sv
// Keyboard front-end for the Enigma core: PS/2 frames -> Set-2 scancodes ->
// one uppercase ASCII letter and a one-cycle strobe per key press. Releases,
// extended keys, non-letters and typematic repeats give no strobe.
//   clk, resetn       : system clock, async active-low reset
//   ps2_clk, ps2_data : raw keyboard lines (asynchronous)
//   core              : letter bus master (char_ascii/char_pressed/frame_error)
// Build option: PS2_PARITY_CHECK_EN enables odd-parity checking in the receiver.
module ps2_letter_input
  import ps2_letter_input_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_letter_input_if.master core
);

  logic       byte_valid, rx_err;
  logic [7:0] byte_data;
  logic       ext, brk;
  logic [7:0] held_code;
  logic [7:0] char_ascii;
  logic       char_pressed;
  letter_t    lk;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_error(rx_err)
  );

  assign lk = sc_to_letter(byte_data);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext          <= 1'b0;
      brk          <= 1'b0;
      held_code    <= 8'h00;
      char_ascii   <= ASCII_A;
      char_pressed <= 1'b0;
    end else begin
      char_pressed <= 1'b0;
      if (rx_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == SC_EXT)        ext <= 1'b1;
        else if (byte_data == SC_BREAK) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (ext) begin
            // extended key (make or release): not a letter
          end else if (brk) begin
            if (byte_data == held_code) held_code <= 8'h00;
          end else if (byte_data != held_code && lk.valid) begin
            // a repeat of held_code is typematic and suppressed above
            held_code    <= byte_data;
            char_ascii   <= lk.ascii;
            char_pressed <= 1'b1;
          end
        end
      end
    end
  end

  assign core.char_ascii   = char_ascii;
  assign core.char_pressed = char_pressed;
  assign core.frame_error  = rx_err;

endmodule

// File: tb/tb_ps2_letter_input.sv
module tb_ps2_letter_input;

  localparam int SYNC   = 2;
  localparam int TMO    = 300;
  localparam int HALF   = 10;   // clk cycles per PS/2 half bit

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_letter_input_if core_if();

  ps2_letter_input #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .core    (core_if.slave)
  );

  always #5 clk = ~clk;

  // Monitor: running totals; tests take differences against snapshots.
  int cyc = 0;
  int n_strobe = 0, n_err = 0, n_both = 0, last_strobe_cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (core_if.char_pressed) begin
      n_strobe++;
      last_strobe_cyc = cyc;
    end
    if (core_if.frame_error) n_err++;
    if (core_if.char_pressed && core_if.frame_error) n_both++;
  end

  int total = 0, passed = 0;
  int stop_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (bad_par ? ^b : ~^b), b, 1'b0};
    send_bits(f, 11);
    repeat (10) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] code;
    int         exp_strobes;
    logic [7:0] exp_ascii;
  } vec_t;

  vec_t vecs[7];
  int s0, e0;

  initial begin
    // make, release per vector; non-letters keep the previous letter
    vecs[0] = '{8'h1C, 1, 8'h41};
    vecs[1] = '{8'h32, 1, 8'h42};
    vecs[2] = '{8'h5A, 0, 8'h42};
    vecs[3] = '{8'h1A, 1, 8'h5A};
    vecs[4] = '{8'h4D, 1, 8'h50};
    vecs[5] = '{8'h16, 0, 8'h50};
    vecs[6] = '{8'h15, 1, 8'h51};

    repeat (3) @(negedge clk);
    check("reset_ascii", core_if.char_ascii, 8'h41);
    check("reset_pressed", core_if.char_pressed, 0);
    check("reset_err", core_if.frame_error, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      s0 = n_strobe; e0 = n_err;
      send_byte(vecs[i].code, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(vecs[i].code, 1'b0);
      check($sformatf("vec%0d_strobes", i), n_strobe - s0, vecs[i].exp_strobes);
      check($sformatf("vec%0d_ascii", i), core_if.char_ascii, vecs[i].exp_ascii);
      check($sformatf("vec%0d_err", i), n_err - e0, 0);
    end

    // 1: press/release A, with latency from the stop-bit edge
    s0 = n_strobe;
    send_byte(8'h1C, 1'b0);
    check("t1_latency", last_strobe_cyc - stop_cyc, SYNC + 2);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    check("t1_strobes", n_strobe - s0, 1);
    check("t1_ascii", core_if.char_ascii, 8'h41);

    // 2: typematic repeats suppressed, re-press after release strobes
    s0 = n_strobe;
    repeat (3) send_byte(8'h1A, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1A, 1'b0);
    send_byte(8'h1A, 1'b0);
    check("t2_strobes", n_strobe - s0, 2);
    check("t2_ascii", core_if.char_ascii, 8'h5A);

    // 3: extended code ignored, Enter ignored
    s0 = n_strobe; e0 = n_err;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'h5A, 1'b0);
    check("t3_strobes", n_strobe - s0, 0);
    check("t3_ascii", core_if.char_ascii, 8'h5A);
    check("t3_err", n_err - e0, 0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1A, 1'b0);

    // 4: bad parity on Q
    s0 = n_strobe; e0 = n_err;
    send_byte(8'h15, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("t4_err", n_err - e0, 1);
    check("t4_strobes", n_strobe - s0, 0);
    check("t4_ascii", core_if.char_ascii, 8'h5A);
`else
    check("t4_err", n_err - e0, 0);
    check("t4_strobes", n_strobe - s0, 1);
    check("t4_ascii", core_if.char_ascii, 8'h51);
`endif
    send_byte(8'hF0, 1'b0);
    send_byte(8'h15, 1'b0);

    // 5: stall after 5 edges -> timeout, then a clean B
    s0 = n_strobe; e0 = n_err;
    send_bits({1'b1, ~^8'h32, 8'h32, 1'b0}, 5);
    repeat (TMO / 2) @(negedge clk);
    check("t5_no_early_err", n_err - e0, 0);
    repeat (TMO) @(negedge clk);
    check("t5_timeout_err", n_err - e0, 1);
    check("t5_no_strobe", n_strobe - s0, 0);
    send_byte(8'h32, 1'b0);
    check("t5_strobes", n_strobe - s0, 1);
    check("t5_ascii", core_if.char_ascii, 8'h42);

    // 6: reset mid-frame, then a clean S
    s0 = n_strobe; e0 = n_err;
    send_bits({1'b1, ~^8'h2D, 8'h2D, 1'b0}, 5);
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_ascii", core_if.char_ascii, 8'h41);
    check("t6_rst_pressed", core_if.char_pressed, 0);
    resetn = 1'b1;
    repeat (TMO + 50) @(negedge clk);
    check("t6_no_err", n_err - e0, 0);
    check("t6_no_strobe", n_strobe - s0, 0);
    send_byte(8'h1B, 1'b0);
    check("t6_strobes", n_strobe - s0, 1);
    check("t6_ascii", core_if.char_ascii, 8'h53);

    check("never_err_and_strobe", n_both, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
